// File: rtl/mnist_top_synth.sv
// mnist_top_synth: self-contained MNIST classifier (784-32-10, ReLU hidden layer, argmax out).
// Three embedded 28x28 images and all weights/biases live in synchronous ROMs whose contents
// are supplied by the environment. A single MAC unit is time-shared across both layers, one MAC per cycle.
// Build option: define MNIST_LOGIT_OUT_EN to add the logit_max output (winning logit).
module mnist_top_synth #(
  parameter string IMG_FILE  = "images.hex",
  parameter string W1_FILE   = "w1.hex",
  parameter string B1_FILE   = "b1.hex",
  parameter string W2_FILE   = "w2.hex",
  parameter string B2_FILE   = "b2.hex",
  parameter int    HID_SHIFT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  img_sel,
  output logic [3:0]  digit,
  output logic        done,
  output logic        valid
`ifdef MNIST_LOGIT_OUT_EN
  ,
  output logic signed [31:0] logit_max
`endif
);

  localparam int NPIX      = 784;
  localparam int NHID      = 32;
  localparam int NOUT      = 10;
  localparam int IMG_WORDS = 3 * NPIX;
  localparam int W1_WORDS  = NHID * NPIX;
  localparam int W2_WORDS  = NOUT * NHID;

  localparam logic [9:0] LAST_PIX = 10'd783;  // last pixel index in layer 1
  localparam logic [9:0] LAST_IN2 = 10'd31;   // last hidden index in layer 2
  localparam logic [4:0] LAST_HID = 5'd31;    // last hidden neuron
  localparam logic [4:0] LAST_OUT = 5'd9;     // last output class

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1,
    S_L2,
    S_ARGMAX,
    S_DONE
  } state_t;

  // ROMs
  logic        [7:0]  img_rom [0:IMG_WORDS-1];
  logic signed [7:0]  w1_rom  [0:W1_WORDS-1];
  logic signed [31:0] b1_rom  [0:NHID-1];
  logic signed [7:0]  w2_rom  [0:W2_WORDS-1];
  logic signed [31:0] b2_rom  [0:NOUT-1];

  // Hidden activations
  logic [7:0] h_rf [0:NHID-1];

  // Control state
  state_t      state_q;
  logic [1:0]  sel_q;
  logic        iss_q;        // still issuing MACs for the current layer
  logic [9:0]  i_q;          // inner index: pixel (L1) or hidden neuron (L2)
  logic [4:0]  n_q;          // outer index: hidden neuron (L1) or class (L2)
  logic [14:0] lin_q;        // linear weight address, inner index fastest

  // Tags travelling alongside the ROM read, one cycle behind the address
  logic        tag_v_q;
  logic        tag_first_q;
  logic        tag_last_q;
  logic [4:0]  tag_idx_q;

  // ROM read registers
  logic        [7:0]  pix_q;
  logic signed [7:0]  w1_q;
  logic signed [31:0] b1_q;
  logic signed [7:0]  w2_q;
  logic signed [31:0] b2_q;
  logic        [7:0]  hrd_q;

  // Datapath state
  logic signed [31:0] acc_q;
  logic signed [31:0] best_q;
  logic        [3:0]  best_idx_q;
  logic        [3:0]  digit_q;
  logic               done_q;
`ifdef MNIST_LOGIT_OUT_EN
  logic signed [31:0] logit_q;
`endif

  // Combinational datapath signals
  logic        [11:0] img_base;
  logic        [11:0] img_addr;
  logic        [7:0]  mac_a;
  logic signed [7:0]  mac_w;
  logic signed [31:0] mac_b;
  logic signed [16:0] a_ext;
  logic signed [16:0] w_ext;
  logic signed [16:0] prod;
  logic signed [31:0] acc_d;
  logic signed [31:0] hid_sh;
  logic        [7:0]  h_d;

  // Image base address for the latched image selection.
  always_comb begin
    case (sel_q)
      2'd1:    img_base = 12'd784;
      2'd2:    img_base = 12'd1568;
      default: img_base = 12'd0;
    endcase
    img_addr = img_base + {2'b00, i_q};
  end

  // Synchronous ROM and register-file reads; data lines up with the tag registers.
  always_ff @(posedge clk) begin
    pix_q <= img_rom[img_addr];
    w1_q  <= w1_rom[lin_q];
    b1_q  <= b1_rom[n_q];
    w2_q  <= w2_rom[lin_q[8:0]];
    b2_q  <= b2_rom[n_q[3:0]];
    hrd_q <= h_rf[i_q[4:0]];
  end

  // MAC operand select, unsigned x signed product, accumulate, and ReLU/shift/saturate.
  always_comb begin
    if (state_q == S_L1) begin
      mac_a = pix_q;
      mac_w = w1_q;
      mac_b = b1_q;
    end else begin
      mac_a = hrd_q;
      mac_w = w2_q;
      mac_b = b2_q;
    end
    a_ext  = {9'b0, mac_a};
    w_ext  = {{9{mac_w[7]}}, mac_w};
    prod   = a_ext * w_ext;
    acc_d  = (tag_first_q ? mac_b : acc_q) + {{15{prod[16]}}, prod};
    hid_sh = acc_d >>> HID_SHIFT;
    if (acc_d[31]) begin
      h_d = 8'd0;
    end else if (hid_sh > 32'sd255) begin
      h_d = 8'd255;
    end else begin
      h_d = hid_sh[7:0];
    end
  end

  // Accumulator and running argmax; a later class wins only on strictly greater.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= 32'sd0;
      best_q     <= 32'sd0;
      best_idx_q <= 4'd0;
    end else if (tag_v_q) begin
      acc_q <= acc_d;
      if (tag_last_q && state_q == S_L2) begin
        if (tag_idx_q == 5'd0 || acc_d > best_q) begin
          best_q     <= acc_d;
          best_idx_q <= tag_idx_q[3:0];
        end
      end
    end
  end

  // Hidden activation write-back at the end of each neuron's accumulation.
  always_ff @(posedge clk) begin
    if (!rst && tag_v_q && tag_last_q && state_q == S_L1) begin
      h_rf[tag_idx_q] <= h_d;
    end
  end

  // Control FSM: address sequencing, MAC tags, registered digit/done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sel_q       <= 2'd0;
      iss_q       <= 1'b0;
      i_q         <= 10'd0;
      n_q         <= 5'd0;
      lin_q       <= 15'd0;
      tag_v_q     <= 1'b0;
      tag_first_q <= 1'b0;
      tag_last_q  <= 1'b0;
      tag_idx_q   <= 5'd0;
      digit_q     <= 4'd0;
      done_q      <= 1'b0;
`ifdef MNIST_LOGIT_OUT_EN
      logit_q     <= 32'sd0;
`endif
    end else begin
      tag_v_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && valid) begin
            sel_q   <= img_sel;
            i_q     <= 10'd0;
            n_q     <= 5'd0;
            lin_q   <= 15'd0;
            iss_q   <= 1'b1;
            state_q <= S_L1;
          end
        end
        S_L1: begin
          if (iss_q) begin
            tag_v_q     <= 1'b1;
            tag_first_q <= (i_q == 10'd0);
            tag_last_q  <= (i_q == LAST_PIX);
            tag_idx_q   <= n_q;
            lin_q       <= lin_q + 15'd1;
            if (i_q == LAST_PIX) begin
              i_q <= 10'd0;
              if (n_q == LAST_HID) iss_q <= 1'b0;
              else                 n_q   <= n_q + 5'd1;
            end else begin
              i_q <= i_q + 10'd1;
            end
          end
          // Final hidden neuron is being written back this cycle.
          if (tag_v_q && tag_last_q && tag_idx_q == LAST_HID) begin
            i_q     <= 10'd0;
            n_q     <= 5'd0;
            lin_q   <= 15'd0;
            iss_q   <= 1'b1;
            state_q <= S_L2;
          end
        end
        S_L2: begin
          if (iss_q) begin
            tag_v_q     <= 1'b1;
            tag_first_q <= (i_q == 10'd0);
            tag_last_q  <= (i_q == LAST_IN2);
            tag_idx_q   <= n_q;
            lin_q       <= lin_q + 15'd1;
            if (i_q == LAST_IN2) begin
              i_q <= 10'd0;
              if (n_q == LAST_OUT) iss_q <= 1'b0;
              else                 n_q   <= n_q + 5'd1;
            end else begin
              i_q <= i_q + 10'd1;
            end
          end
          if (tag_v_q && tag_last_q && tag_idx_q == LAST_OUT) begin
            state_q <= S_ARGMAX;
          end
        end
        S_ARGMAX: begin
          digit_q <= best_idx_q;
`ifdef MNIST_LOGIT_OUT_EN
          logit_q <= best_q;
`endif
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign valid = (img_sel != 2'b11);
  assign digit = digit_q;
  assign done  = done_q;
`ifdef MNIST_LOGIT_OUT_EN
  assign logit_max = logit_q;
`endif

endmodule

// File: tb/tb_mnist_top_synth.sv
// tb_mnist_top_synth: directed bench for mnist_top_synth.
// ROM contents are a small hand-built network loaded into the DUT memories so that
// image 0 -> 6 (logit 1065), image 1 -> 2 (logit 1020, tie with class 8), image 2 -> 3 (logit 990).
module tb_mnist_top_synth;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] img_sel = 2'd0;
  logic [3:0] digit;
  logic       done;
  logic       valid;
`ifdef MNIST_LOGIT_OUT_EN
  logic signed [31:0] logit_max;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  typedef struct {
    logic [1:0] sel;
    logic       exp_v;
  } vv_t;

  typedef struct {
    string              name;
    logic [1:0]         sel;
    bit                 mid;
    logic [3:0]         exp_d;
    logic signed [31:0] exp_l;
  } run_t;

  mnist_top_synth #(
    .IMG_FILE(""),
    .W1_FILE(""),
    .B1_FILE(""),
    .W2_FILE(""),
    .B2_FILE(""),
    .HID_SHIFT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .img_sel(img_sel),
    .digit(digit),
    .done(done),
    .valid(valid)
`ifdef MNIST_LOGIT_OUT_EN
    ,
    .logit_max(logit_max)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_roms();
    for (int k = 0; k < 2352; k++)  dut.img_rom[k] = 8'd0;
    for (int k = 0; k < 25088; k++) dut.w1_rom[k]  = 8'sd0;
    for (int k = 0; k < 32; k++)    dut.b1_rom[k]  = 32'sd0;
    for (int k = 0; k < 320; k++)   dut.w2_rom[k]  = 8'sd0;
    for (int k = 0; k < 10; k++)    dut.b2_rom[k]  = 32'(-1000);
    // images
    dut.img_rom[0 * 784 + 100] = 8'd255;
    dut.img_rom[0 * 784 + 783] = 8'd2;
    dut.img_rom[1 * 784 + 0]   = 8'd128;
    dut.img_rom[1 * 784 + 500] = 8'd255;
    dut.img_rom[2 * 784 + 400] = 8'd64;
    dut.img_rom[2 * 784 + 783] = 8'd200;
    // hidden layer
    dut.w1_rom[0 * 784 + 100]  = 8'sd127;
    dut.w1_rom[0 * 784 + 0]    = 8'(-128);
    dut.w1_rom[5 * 784 + 500]  = 8'sd100;
    dut.b1_rom[5]              = 32'sd50000;
    dut.w1_rom[10 * 784 + 400] = 8'(-50);
    dut.w1_rom[10 * 784 + 783] = 8'sd60;
    dut.b1_rom[10]             = 32'(-256);
    dut.w1_rom[31 * 784 + 783] = 8'(-3);
    dut.b1_rom[31]             = 32'sd512;
    // output layer
    dut.b2_rom[2] = 32'sd0;
    dut.b2_rom[3] = 32'sd0;
    dut.b2_rom[6] = 32'sd0;
    dut.b2_rom[8] = 32'sd766;
    dut.w2_rom[6 * 32 + 0]  = 8'sd10;
    dut.w2_rom[6 * 32 + 5]  = 8'(-1);
    dut.w2_rom[2 * 32 + 5]  = 8'sd4;
    dut.w2_rom[3 * 32 + 10] = 8'sd30;
    dut.w2_rom[8 * 32 + 31] = 8'sd127;
  endtask

  task automatic run_img(input string name, input logic [1:0] sel, input bit mid,
                         input logic [3:0] exp_d, input logic signed [31:0] exp_l);
    int cyc;
    int base;
    base = done_cnt;
    @(negedge clk);
    img_sel = sel;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (done !== 1'b1 && cyc < 26500) begin
      if (mid && cyc == 3000) begin
        img_sel = 2'd2;
        start   = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || cyc > 26000) begin
      n_bad++;
      $display("FAIL %s latency: got %0d cycles (done=%b) required <= 26000", name, cyc, done);
    end
    chk({name, " digit"}, {28'd0, digit}, {28'd0, exp_d});
`ifdef MNIST_LOGIT_OUT_EN
    chk({name, " logit"}, logit_max, exp_l);
`else
    if (exp_l == 32'sd0) $display("note: %s has zero expected logit", name);
`endif
    @(negedge clk);
    chk({name, " done_drop"}, {31'd0, done}, 32'd0);
    chk({name, " digit_hold"}, {28'd0, digit}, {28'd0, exp_d});
    repeat (20) @(negedge clk);
    chk({name, " done_pulses"}, done_cnt - base, 32'd1);
  endtask

  initial begin
    vv_t  vv[4];
    run_t runs[2];
    int   base;

    vv[0] = '{sel: 2'd0, exp_v: 1'b1};
    vv[1] = '{sel: 2'd1, exp_v: 1'b1};
    vv[2] = '{sel: 2'd2, exp_v: 1'b1};
    vv[3] = '{sel: 2'd3, exp_v: 1'b0};
    runs[0] = '{name: "img0_midstart", sel: 2'd0, mid: 1'b1, exp_d: 4'd6, exp_l: 32'sd1065};
    runs[1] = '{name: "img1_tie",      sel: 2'd1, mid: 1'b0, exp_d: 4'd2, exp_l: 32'sd1020};

    #1;
    load_roms();

    // reset
    rst = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset digit", {28'd0, digit}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset valid", {31'd0, valid}, 32'd1);

    // valid is combinational on img_sel
    for (int k = 0; k < 4; k++) begin
      img_sel = vv[k].sel;
      #1;
      chk($sformatf("valid sel=%0d", vv[k].sel), {31'd0, valid}, {31'd0, vv[k].exp_v});
    end

    // start with an illegal image index is ignored
    base = done_cnt;
    @(negedge clk);
    img_sel = 2'd3;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    chk("invalid start done", done_cnt - base, 32'd0);
    chk("invalid start digit", {28'd0, digit}, 32'd0);

    // table-driven full inferences
    for (int k = 0; k < 2; k++) begin
      run_img(runs[k].name, runs[k].sel, runs[k].mid, runs[k].exp_d, runs[k].exp_l);
    end

    // reset mid-run aborts the inference
    base = done_cnt;
    @(negedge clk);
    img_sel = 2'd0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5000) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort digit", {28'd0, digit}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    repeat (200) @(negedge clk);
    chk("abort no done", done_cnt - base, 32'd0);

    run_img("img2_restart", 2'd2, 1'b0, 4'd3, 32'sd990);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
